// File: rtl/e_mdu_if.sv
// Operand/result bundle between the E-stage datapath and the multiply/divide unit.
interface e_mdu_if;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic [2:0]  MDUOp;
    logic        Start;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (output SrcA, SrcB, MDUOp, Start, input Busy, HI, LO);
    modport slave  (input SrcA, SrcB, MDUOp, Start, output Busy, HI, LO);
endinterface

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: fixed-latency mult/div with HI/LO registers.
// The 64-bit result is formed at the start edge, parked in a temp pair, and committed when the counter expires.
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic    clk,
    input  logic    reset,
    e_mdu_if.slave  bus
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    state_t      state, state_next;
    logic [3:0]  cnt, cnt_next;
    logic [31:0] t_hi, t_hi_next;
    logic [31:0] t_lo, t_lo_next;
    logic        t_wr, t_wr_next;
    logic [31:0] hi, hi_next;
    logic [31:0] lo, lo_next;

    logic [63:0] op_res;
    logic        op_wr;

    function automatic logic [63:0] mul_signed(input logic signed [31:0] a,
                                                input logic signed [31:0] b);
        logic [63:0] ax, bx;
        ax = {{32{a[31]}}, a};
        bx = {{32{b[31]}}, b};
        return ax * bx;
    endfunction

    function automatic logic [63:0] mul_unsigned(input logic [31:0] a,
                                                  input logic [31:0] b);
        logic [63:0] ax, bx;
        ax = {32'd0, a};
        bx = {32'd0, b};
        return ax * bx;
    endfunction

    // Returns {remainder, quotient}; a zero divisor is replaced so the divider never sees it.
    function automatic logic [63:0] div_unsigned(input logic [31:0] a,
                                                  input logic [31:0] b);
        logic [31:0] d;
        d = (b == 32'd0) ? 32'd1 : b;
        return {a % d, a / d};
    endfunction

    // Works on magnitudes so -2^31 / -1 falls out as 0x80000000 rem 0 without overflow.
    function automatic logic [63:0] div_signed(input logic signed [31:0] a,
                                                input logic signed [31:0] b);
        logic [31:0] ma, mb, q, r;
        logic [63:0] qr;
        ma = a[31] ? (32'd0 - a) : a;
        mb = b[31] ? (32'd0 - b) : b;
        qr = div_unsigned(ma, mb);
        q  = qr[31:0];
        r  = qr[63:32];
        if (a[31] ^ b[31]) q = 32'd0 - q;
        if (a[31])         r = 32'd0 - r;
        return {r, q};
    endfunction

    always_comb begin
        op_res = 64'd0;
        op_wr  = 1'b1;
        case (bus.MDUOp)
            OP_MULT:  op_res = mul_signed(bus.SrcA, bus.SrcB);
            OP_MULTU: op_res = mul_unsigned(bus.SrcA, bus.SrcB);
            OP_DIV: begin
                op_res = div_signed(bus.SrcA, bus.SrcB);
                op_wr  = (bus.SrcB != 32'd0);
            end
            OP_DIVU: begin
                op_res = div_unsigned(bus.SrcA, bus.SrcB);
                op_wr  = (bus.SrcB != 32'd0);
            end
            default: begin
                op_res = 64'd0;
                op_wr  = 1'b1;
            end
        endcase
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        t_hi_next  = t_hi;
        t_lo_next  = t_lo;
        t_wr_next  = t_wr;
        hi_next    = hi;
        lo_next    = lo;
        case (state)
            IDLE: begin
                if (bus.Start) begin
                    case (bus.MDUOp)
                        OP_MULT, OP_MULTU: begin
                            t_hi_next  = op_res[63:32];
                            t_lo_next  = op_res[31:0];
                            t_wr_next  = op_wr;
                            cnt_next   = 4'(MULT_CYCLES);
                            state_next = RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            t_hi_next  = op_res[63:32];
                            t_lo_next  = op_res[31:0];
                            t_wr_next  = op_wr;
                            cnt_next   = 4'(DIV_CYCLES);
                            state_next = RUN;
                        end
                        OP_MTHI: hi_next = bus.SrcA;
                        OP_MTLO: lo_next = bus.SrcA;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                // Any Start seen here is dropped; the hazard unit should never send one.
                cnt_next = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_next = IDLE;
                    if (t_wr) begin
                        hi_next = t_hi;
                        lo_next = t_lo;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
            t_hi  <= 32'd0;
            t_lo  <= 32'd0;
            t_wr  <= 1'b0;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            t_hi  <= t_hi_next;
            t_lo  <= t_lo_next;
            t_wr  <= t_wr_next;
            hi    <= hi_next;
            lo    <= lo_next;
        end
    end

    assign bus.Busy = (state == RUN);
    assign bus.HI   = hi;
    assign bus.LO   = lo;

endmodule

// File: tb/tb_e_mdu.sv
// Directed-vector bench for e_mdu: result values, Busy length, HI/LO hold and async reset.
module tb_e_mdu;

    logic clk;
    logic reset;
    e_mdu_if mdu_bus();

    e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (mdu_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
        bit          inj;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] cur_hi = 32'd0;
    logic [31:0] cur_lo = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Drives immediately (no wait) so consecutive calls issue back-to-back in the first Busy=0 cycle.
    task automatic run_op(input vec_t v);
        int n;
        mdu_bus.Start = 1'b1;
        mdu_bus.MDUOp = v.op;
        mdu_bus.SrcA  = v.a;
        mdu_bus.SrcB  = v.b;
        @(negedge clk);
        mdu_bus.Start = 1'b0;
        n = 0;
        while (mdu_bus.Busy === 1'b1 && n < 40) begin
            n++;
            check({v.name, " hold HI"}, mdu_bus.HI, cur_hi);
            check({v.name, " hold LO"}, mdu_bus.LO, cur_lo);
            mdu_bus.SrcA = $urandom;
            mdu_bus.SrcB = $urandom;
            if (v.inj) begin
                mdu_bus.Start = 1'b1;
                mdu_bus.MDUOp = n[0] ? 3'd6 : 3'd5;
            end
            @(negedge clk);
        end
        check({v.name, " busy cycles"}, 32'(n), 32'(v.cycles));
        check({v.name, " HI"}, mdu_bus.HI, v.hi);
        check({v.name, " LO"}, mdu_bus.LO, v.lo);
        cur_hi = v.hi;
        cur_lo = v.lo;
    endtask

    vec_t vecs[$];
    vec_t tail;
    int   busy_seen;

    initial begin
        vecs.push_back('{"mult -2*3",      3'd1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5,  1'b0});
        vecs.push_back('{"multu",          3'd2, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, 5,  1'b0});
        vecs.push_back('{"div -7/2",       3'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10, 1'b0});
        vecs.push_back('{"divu 7/2",       3'd4, 32'd7,        32'd2,        32'h00000001, 32'h00000003, 10, 1'b0});
        vecs.push_back('{"div min/-1",     3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10, 1'b0});
        vecs.push_back('{"div 7/-2",       3'd3, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10, 1'b0});
        vecs.push_back('{"mthi",           3'd5, 32'h11111111, 32'd0,        32'h11111111, 32'hFFFFFFFD, 0,  1'b0});
        vecs.push_back('{"mtlo",           3'd6, 32'h22222222, 32'd0,        32'h11111111, 32'h22222222, 0,  1'b0});
        vecs.push_back('{"divu x/0",       3'd4, 32'd5,        32'd0,        32'h11111111, 32'h22222222, 10, 1'b0});
        vecs.push_back('{"div x/0",        3'd3, 32'hFFFFFFFB, 32'd0,        32'h11111111, 32'h22222222, 10, 1'b0});
        vecs.push_back('{"op none",        3'd0, 32'h99999999, 32'd1,        32'h11111111, 32'h22222222, 0,  1'b0});
        vecs.push_back('{"op reserved",    3'd7, 32'h99999999, 32'd1,        32'h11111111, 32'h22222222, 0,  1'b0});
        vecs.push_back('{"mult max*max",   3'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 5,  1'b1});
        vecs.push_back('{"multu ff*ff",    3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5,  1'b1});
        vecs.push_back('{"mult 3*4 inj",   3'd1, 32'd3,        32'd4,        32'h00000000, 32'h0000000C, 5,  1'b1});
        vecs.push_back('{"divu b2b",       3'd4, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 10, 1'b0});

        reset = 1'b0;
        mdu_bus.Start = 1'b0;
        mdu_bus.MDUOp = 3'd0;
        mdu_bus.SrcA  = 32'd0;
        mdu_bus.SrcB  = 32'd0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("reset HI", mdu_bus.HI, 32'd0);
        check("reset LO", mdu_bus.LO, 32'd0);
        check("reset Busy", 32'(mdu_bus.Busy), 32'd0);

        foreach (vecs[i]) run_op(vecs[i]);

        // mthi then mtlo on consecutive cycles, Busy must never rise
        mdu_bus.Start = 1'b1;
        mdu_bus.MDUOp = 3'd5;
        mdu_bus.SrcA  = 32'hDEADBEEF;
        @(negedge clk);
        check("mthi HI", mdu_bus.HI, 32'hDEADBEEF);
        check("mthi LO", mdu_bus.LO, 32'h0000000E);
        check("mthi Busy", 32'(mdu_bus.Busy), 32'd0);
        mdu_bus.MDUOp = 3'd6;
        mdu_bus.SrcA  = 32'h12345678;
        @(negedge clk);
        mdu_bus.Start = 1'b0;
        check("mtlo HI", mdu_bus.HI, 32'hDEADBEEF);
        check("mtlo LO", mdu_bus.LO, 32'h12345678);
        check("mtlo Busy", 32'(mdu_bus.Busy), 32'd0);
        cur_hi = 32'hDEADBEEF;
        cur_lo = 32'h12345678;

        // Asynchronous reset in the 3rd cycle of a div discards the pending result
        mdu_bus.Start = 1'b1;
        mdu_bus.MDUOp = 3'd3;
        mdu_bus.SrcA  = 32'd100;
        mdu_bus.SrcB  = 32'd7;
        @(negedge clk);
        mdu_bus.Start = 1'b0;
        check("pre-reset Busy", 32'(mdu_bus.Busy), 32'd1);
        @(negedge clk);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("async reset Busy", 32'(mdu_bus.Busy), 32'd0);
        check("async reset HI", mdu_bus.HI, 32'd0);
        check("async reset LO", mdu_bus.LO, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        busy_seen = 0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (mdu_bus.Busy !== 1'b0 || mdu_bus.HI !== 32'd0 || mdu_bus.LO !== 32'd0)
                busy_seen++;
        end
        check("no commit after reset", 32'(busy_seen), 32'd0);
        cur_hi = 32'd0;
        cur_lo = 32'd0;

        tail = '{"mult after reset", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 5, 1'b0};
        run_op(tail);
        mdu_bus.Start = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Execute-stage multiply/divide unit. Sits beside the E-stage ALU and consumes the same forwarded SrcA/SrcB operands.
- Runs mult/multu/div/divu as fixed-latency multi-cycle operations, holds the HI/LO architectural registers and handles mthi/mtlo.
- Drives Busy so the hazard unit can stall any later MDU instruction while an operation is in flight.

Parameters:
MULT_CYCLES, 5, cycles Busy stays high for mult/multu (legal range 1..15)
DIV_CYCLES, 10, cycles Busy stays high for div/divu (legal range 1..15)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
SrcA  input  32  operand A (rs), already forwarded
SrcB  input  32  operand B (rt), already forwarded
MDUOp  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
Start  input  1  qualifies MDUOp this cycle; high only for the E-stage instruction
Busy  output  1  operation in flight (registered)
HI  output  32  HI register
LO  output  32  LO register

Behaviour:
- Reset (reset=0, asynchronous): HI=0, LO=0, Busy=0, counter=0, state=IDLE, temp result regs=0. Takes effect immediately, including mid-operation. A pending result is discarded and HI/LO stay 0.
- State machine has two states, IDLE and RUN.
- IDLE:
  - Start=1 with MDUOp 1..4: at the edge, latch the 64-bit result into temp {tHI,tLO}, load the counter with MULT_CYCLES or DIV_CYCLES, go to RUN, Busy=1 after that edge.
  - Start=1 with MDUOp 5: HI<=SrcA at the edge. Busy stays 0.
  - Start=1 with MDUOp 6: LO<=SrcA at the edge. Busy stays 0.
  - MDUOp 0 or 7, or Start=0: no change.
- RUN:
  - Counter decrements each edge.
  - On the edge where the counter goes 1->0: HI<=tHI, LO<=tLO, state->IDLE, Busy->0.
  - Busy is therefore high for exactly N cycles after the start edge. The new HI/LO are visible in the first cycle Busy=0.
  - HI/LO keep their old values throughout RUN.
- Start while Busy=1 (any MDUOp, including mthi/mtlo): ignored. The hazard unit guarantees this does not happen. Verification checks that it is ignored.
- Arithmetic:
  - mult: signed 32x32->64, HI=upper, LO=lower.
  - multu: unsigned 32x32->64.
  - div: signed. LO=quotient truncated toward zero, HI=remainder with the sign of the dividend.
  - divu: unsigned quotient/remainder.
  - div -2^31 / -1: LO=0x80000000, HI=0.
- Divide by zero (SrcB=0, div or divu): the operation still occupies DIV_CYCLES and Busy behaves normally. HI and LO are left unchanged at commit.
- Operands are sampled only at the start edge. Later changes to SrcA/SrcB have no effect.
- Back-to-back: Start may be asserted in the first cycle Busy=0 and is accepted normally.
- No combinational path from any input to Busy, HI or LO.

Test Plan:
- Reset: hold reset=0 for 2 cycles, release -> HI=0, LO=0, Busy=0. Assert reset=0 asynchronously in the 3rd cycle of a div -> Busy drops immediately, HI=LO=0 after release, no later commit.
- mult: SrcA=0xFFFFFFFE (-2), SrcB=3, Start with MDUOp=1 -> Busy=1 for exactly 5 cycles, HI/LO unchanged meanwhile, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. Repeat with multu -> HI=0x00000002, LO=0xFFFFFFFA.
- div: SrcA=-7, SrcB=2, MDUOp=3 -> Busy 10 cycles, then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). divu 7/2 -> LO=3, HI=1. Edge case -2^31/-1 -> LO=0x80000000, HI=0.
- Divide by zero: preload HI=0x11111111, LO=0x22222222 via mthi/mtlo, then divu x/0 -> Busy 10 cycles, HI/LO unchanged.
- mthi/mtlo: mthi 0xDEADBEEF then mtlo 0x12345678 on consecutive cycles -> HI/LO updated one edge after each, Busy never high. mtlo issued while a mult is busy -> ignored, LO gets the mult result at commit.
- Operand hold and back-to-back: change SrcA/SrcB every cycle during a mult -> result uses the start-edge operands. Start a div in the first cycle Busy=0 -> accepted, Busy high for 10 more cycles.
